// File: rtl/debug_unit_cmd_if.sv
// debug_unit_cmd_if: UART-side and core-side signal bundle of the command debug unit
interface debug_unit_cmd_if #(
    parameter int DATA_BITS = 8,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
);
    logic [DATA_BITS-1:0]        rx_dato_out;
    logic                        rx_done;
    logic                        tx_done;
    logic [NUM_WORDS*WORD_W-1:0] dbg_data;
    logic                        enable;
    logic [DATA_BITS-1:0]        tx_dato_in;
    logic                        tx_start;
    logic                        busy;
    modport master (
        output rx_dato_out, rx_done, tx_done, dbg_data,
        input  enable, tx_dato_in, tx_start, busy
    );
    modport slave (
        input  rx_dato_out, rx_done, tx_done, dbg_data,
        output enable, tx_dato_in, tx_start, busy
    );
endinterface

// File: rtl/debug_unit_cmd.sv
// debug_unit_cmd: decodes UART command bytes to run/halt/step the core and dumps the debug bus; DEBUG_CHECKSUM_EN appends an XOR byte to dumps
module debug_unit_cmd #(
    parameter int DATA_BITS = 8,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
) (
    input logic clk,
    input logic reset,
    debug_unit_cmd_if.slave bus
);
    localparam int SNAP_W = NUM_WORDS * WORD_W;
    localparam int DUMP_N = SNAP_W / DATA_BITS;
`ifdef DEBUG_CHECKSUM_EN
    localparam int MAX_N = DUMP_N + 1;
`else
    localparam int MAX_N = DUMP_N;
`endif
    localparam int IDX_W = $clog2(MAX_N + 1);
    localparam logic [DATA_BITS-1:0] CMD_C = DATA_BITS'(8'h63);
    localparam logic [DATA_BITS-1:0] CMD_H = DATA_BITS'(8'h68);
    localparam logic [DATA_BITS-1:0] CMD_S = DATA_BITS'(8'h73);
    localparam logic [DATA_BITS-1:0] CMD_P = DATA_BITS'(8'h70);
    localparam logic [DATA_BITS-1:0] ACK   = DATA_BITS'(8'h4B);
    localparam logic [DATA_BITS-1:0] NAK   = DATA_BITS'(8'h3F);

    typedef enum logic [1:0] {IDLE, DECODE, SEND, WAIT_TX} state_t;

    state_t               r_state;
    logic                 r_rx_q;
    logic                 r_tx_q;
    logic [DATA_BITS-1:0] r_cmd;
    logic [SNAP_W-1:0]    r_snap;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_last;
    logic                 r_is_dump;
    logic                 r_step;
    logic                 r_enable;
    logic                 r_tx_start;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 w_rx_ev;
    logic                 w_tx_ev;
    logic [SNAP_W-1:0]    w_ordered;
    logic [DATA_BITS-1:0] w_head;
    logic [DATA_BITS-1:0] w_reply;
    logic [DATA_BITS-1:0] w_byte;

    assign w_rx_ev = bus.rx_done & ~r_rx_q;
    assign w_tx_ev = bus.tx_done & ~r_tx_q;
    assign w_head  = r_snap[SNAP_W-1 -: DATA_BITS];
    assign w_reply = (r_cmd == CMD_C || r_cmd == CMD_H || r_cmd == CMD_S) ? ACK : NAK;

    // Word 0 goes to the top of the snapshot so the dump is a plain MSB-first shift-out
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_ord
        assign w_ordered[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = bus.dbg_data[k*WORD_W +: WORD_W];
    end

`ifdef DEBUG_CHECKSUM_EN
    logic [DATA_BITS-1:0] r_csum;
    assign w_byte = (r_is_dump && r_idx == IDX_W'(DUMP_N)) ? r_csum : w_head;
    // Running XOR of dump bytes, folded in as each byte is acknowledged
    always_ff @(posedge clk) begin
        if (reset || r_state == DECODE)
            r_csum <= '0;
        else if (r_state == WAIT_TX && w_tx_ev)
            r_csum <= r_csum ^ r_tx_data;
    end
`else
    assign w_byte = w_head;
`endif

    // Previous level of the UART done flags; a held-high flag gives a single event
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_q <= 1'b0;
            r_tx_q <= 1'b0;
        end else begin
            r_rx_q <= bus.rx_done;
            r_tx_q <= bus.tx_done;
        end
    end

    // Command FSM: capture, decode, then shift out reply or snapshot one byte per TX handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cmd      <= '0;
            r_snap     <= '0;
            r_idx      <= '0;
            r_last     <= '0;
            r_is_dump  <= 1'b0;
            r_step     <= 1'b0;
            r_enable   <= 1'b0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rx_ev) begin
                        r_cmd   <= bus.rx_dato_out;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_is_dump <= r_cmd == CMD_P;
                    r_last    <= r_cmd == CMD_P ? IDX_W'(MAX_N - 1) : '0;
                    r_snap    <= r_cmd == CMD_P ? w_ordered : SNAP_W'(w_reply) << (SNAP_W - DATA_BITS);
                    r_enable  <= r_cmd == CMD_C ? 1'b1 :
                                 r_cmd == CMD_H ? 1'b0 :
                                 r_cmd == CMD_S ? ~r_enable : r_enable;
                    r_step    <= r_cmd == CMD_S && !r_enable;
                    r_state   <= SEND;
                end
                SEND: begin
                    if (r_step) begin
                        r_enable <= 1'b0;
                        r_step   <= 1'b0;
                    end
                    r_tx_data  <= w_byte;
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (w_tx_ev) begin
                        r_tx_start <= 1'b0;
                        r_snap     <= r_snap << DATA_BITS;
                        if (r_idx == r_last) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.enable     = r_enable;
    assign bus.tx_dato_in = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_debug_unit_cmd.sv
// tb_debug_unit_cmd: directed and randomized command bench for debug_unit_cmd with a behavioural reply model
module tb_debug_unit_cmd;
    localparam int DB = 8;
    localparam int WW = 32;
    localparam int NW = 4;
    localparam int NB = NW * WW / DB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    bit m_en = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    debug_unit_cmd_if #(.DATA_BITS(DB), .WORD_W(WW), .NUM_WORDS(NW)) bus();
    debug_unit_cmd #(.DATA_BITS(DB), .WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // Counts cycles with the core enabled, used to measure the single-step pulse
    always @(negedge clk) if (bus.enable) en_cnt <= en_cnt + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model(input logic [7:0] c, input logic [NW*WW-1:0] d);
        logic [7:0] x;
        exp_q.delete();
        x = 8'h00;
        if (c == 8'h70) begin
            for (int k = 0; k < NW; k++)
                for (int b = WW/DB - 1; b >= 0; b--)
                    exp_q.push_back(8'((d >> (k*WW + b*DB)) & 128'hFF));
`ifdef DEBUG_CHECKSUM_EN
            foreach (exp_q[i]) x = x ^ exp_q[i];
            exp_q.push_back(x);
`endif
        end else begin
            exp_q.push_back((c == 8'h63 || c == 8'h68 || c == 8'h73) ? 8'h4B : 8'h3F);
            if (c == 8'h63) m_en = 1'b1;
            else if (c == 8'h68 || c == 8'h73) m_en = 1'b0;
        end
    endtask

    task automatic serve(input bit inject, input bit scramble, input string tag);
        int guard;
        bit first;
        bit stable;
        logic [7:0] b;
        got.delete();
        guard = 0;
        first = 1'b1;
        while (guard < 2000) begin
            if (!bus.busy && !bus.tx_start) break;
            if (bus.tx_start) begin
                b = bus.tx_dato_in;
                got.push_back(b);
                stable = 1'b1;
                if (first && inject) begin
                    bus.rx_dato_out = 8'h63;
                    bus.rx_done = 1'b1;
                    tick();
                    bus.rx_done = 1'b0;
                    if (bus.tx_start !== 1'b1 || bus.tx_dato_in !== b) stable = 1'b0;
                end
                if (first && scramble) bus.dbg_data = {$urandom, $urandom, $urandom, $urandom};
                first = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    if (bus.tx_start !== 1'b1 || bus.tx_dato_in !== b) stable = 1'b0;
                end
                chk($sformatf("%s_hold%0d", tag, got.size()), {31'd0, stable}, 32'd1);
                bus.tx_done = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                bus.tx_done = 1'b0;
                tick();
                guard += 8;
            end else begin
                tick();
                guard++;
            end
        end
        chk({tag, "_timeout"}, {31'd0, guard < 2000}, 32'd1);
    endtask

    task automatic do_cmd(input logic [7:0] c, input int hold, input bit inject, input bit scramble, input string tag);
        bit was_en;
        int e0;
        was_en = m_en;
        model(c, bus.dbg_data);
        e0 = en_cnt;
        bus.rx_dato_out = c;
        bus.rx_done = 1'b1;
        repeat (hold) tick();
        bus.rx_done = 1'b0;
        serve(inject, scramble, tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        chk({tag, "_enable"}, {31'd0, bus.enable}, {31'd0, m_en});
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        if (c == 8'h73 && !was_en) chk({tag, "_step_pulse"}, en_cnt - e0, 32'd1);
    endtask

    initial begin
        logic [7:0] fixed_exp[16];
        logic [7:0] cmds[4];
        logic [7:0] c;
        fixed_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
        cmds = '{8'h63, 8'h68, 8'h73, 8'h70};
        bus.rx_dato_out = '0;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        bus.dbg_data = '0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_enable", {31'd0, bus.enable}, 32'd0);
        chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("rst_tx_dato", {24'd0, bus.tx_dato_in}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        tick();

        model(8'h63, bus.dbg_data);
        bus.rx_dato_out = 8'h63;
        bus.rx_done = 1'b1;
        tick();
        chk("lat_busy", {31'd0, bus.busy}, 32'd1);
        chk("lat_start0", {31'd0, bus.tx_start}, 32'd0);
        tick();
        chk("lat_start1", {31'd0, bus.tx_start}, 32'd0);
        tick();
        chk("lat_start2", {31'd0, bus.tx_start}, 32'd1);
        chk("lat_byte", {24'd0, bus.tx_dato_in}, 32'h4B);
        bus.rx_done = 1'b0;
        serve(1'b0, 1'b0, "run");
        chk("run_count", got.size(), 32'd1);
        chk("run_enable", {31'd0, bus.enable}, 32'd1);
        chk("run_busy", {31'd0, bus.busy}, 32'd0);
        repeat (4) tick();
        chk("run_enable_held", {31'd0, bus.enable}, 32'd1);

        do_cmd(8'h68, 1, 1'b0, 1'b0, "halt");
        do_cmd(8'h73, 2, 1'b0, 1'b0, "step");
        do_cmd(8'h63, 1, 1'b0, 1'b0, "run2");
        do_cmd(8'h73, 1, 1'b0, 1'b0, "step_as_halt");

        bus.dbg_data = {32'h44332211, 32'hDDCCBBAA, 32'h00000000, 32'h12345678};
        do_cmd(8'h70, 1, 1'b0, 1'b1, "dump");
        for (int i = 0; i < 16; i++)
            if (i < got.size()) chk($sformatf("dump_fixed%0d", i), {24'd0, got[i]}, {24'd0, fixed_exp[i]});

        do_cmd(8'h78, 1, 1'b1, 1'b0, "bad_drop");
        do_cmd(8'h78, 5, 1'b0, 1'b0, "bad_held");

        for (int n = 0; n < 24; n++) begin
            c = $urandom_range(0, 4) == 4 ? 8'($urandom) : cmds[$urandom_range(0, 3)];
            bus.dbg_data = {$urandom, $urandom, $urandom, $urandom};
            do_cmd(c, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        do_cmd(8'h63, 1, 1'b0, 1'b0, "pre_abort");
        bus.rx_dato_out = 8'h70;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        repeat (6) tick();
        chk("abort_in_dump", {31'd0, bus.tx_start}, 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_enable", {31'd0, bus.enable}, 32'd0);
        reset = 1'b0;
        m_en = 1'b0;
        tick();
        do_cmd(8'h63, 1, 1'b0, 1'b0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debug_unit_cmd.md
Name: debug_unit_cmd

Overview:
- Parametrised successor of the single-byte UART echo debug unit.
- Sits between the UART RX/TX pair and the MIPS core.
- Decodes one-byte commands from RX to run, halt or single-step the core via `enable`.
- Dumps a snapshot of a wide debug bus (PC, registers, etc.) back over TX as a byte stream.

Parameters:
- DATA_BITS, 8, UART character width; width of `rx_dato_out` and `tx_dato_in`.
- WORD_W, 32, width of one debug word; must be a multiple of DATA_BITS.
- NUM_WORDS, 4, number of debug words on `dbg_data`; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_dato_out  in  DATA_BITS  byte received by UART RX; valid while rx_done=1.
- rx_done  in  1  RX byte-complete flag; level, may stay high several cycles.
- tx_done  in  1  TX byte-complete flag; level, may stay high several cycles.
- dbg_data  in  NUM_WORDS*WORD_W  debug bus; word k = bits [k*WORD_W +: WORD_W].
- enable  out  1  core clock-enable.
- tx_dato_in  out  DATA_BITS  byte presented to UART TX.
- tx_start  out  1  TX request.
- busy  out  1  high while a reply/dump is in progress.

Behaviour:
- Reset state: enable=0, tx_start=0, tx_dato_in=0, busy=0, state IDLE, counters 0.
  - reset=1 mid-dump aborts the dump; tx_start is low the next cycle.
- Edge detect:
  - rx_done and tx_done are each registered once.
  - An event is the registered-low / current-high rising edge.
  - A held-high flag yields exactly one event.
- States: IDLE, DECODE, SEND, WAIT_TX.
- IDLE:
  - On an rx event, capture rx_dato_out into cmd and go to DECODE.
  - Otherwise stay.
- DECODE (one cycle), busy=1:
  - 'c' (0x63): enable←1; reply 'K' (0x4B).
  - 'h' (0x68): enable←0; reply 'K'.
  - 's' (0x73), when enable=0: enable←1 for exactly one cycle, then 0 (the core advances one instruction); reply 'K'.
  - 's' (0x73), when enable=1: acts as 'h'.
  - 'p' (0x70): latch dbg_data into a snapshot register this cycle; enable unchanged.
    - Byte count = NUM_WORDS*WORD_W/DATA_BITS.
    - Order: word 0 first; within a word, most-significant byte first.
  - Any other byte: reply '?' (0x3F).
  - Then go to SEND.
- SEND:
  - Drive tx_dato_in with the current reply/dump byte.
  - tx_start←1; go to WAIT_TX.
- WAIT_TX:
  - Hold tx_start=1 and tx_dato_in stable until a tx event.
  - On the tx event, tx_start←0.
  - If more bytes remain, increment the byte index and go to SEND (next byte starts ≥1 cycle later).
  - Otherwise busy←0 and go to IDLE.
- Dropped bytes: rx events while busy=1 (DECODE/SEND/WAIT_TX) are ignored, with no queueing. A tx event outside WAIT_TX is ignored.
- Counter: byte index width clog2(total bytes + 1); wrap-free, reset to 0 on each new command.
- Latency: rx event → DECODE next cycle → tx_start high 2 cycles after the rx event.

Optional Feature:
- Macro DEBUG_CHECKSUM_EN.
- When defined, a 'p' dump is followed by one extra byte: the XOR of all dump bytes. Total bytes = dump count + 1; the checksum is computed incrementally as bytes are sent.
- When undefined, no checksum byte is sent and the checksum logic is absent.

Test Plan:
- Reset, then send 'c' → enable=1 and stays; one TX byte 0x4B; busy returns to 0.
- From halt, send 's' → enable high for exactly 1 clk; TX 0x4B. Then send 'c', then 's' → enable=0 (acts as halt).
- dbg_data={32'h44332211,32'hDDCCBBAA,32'h00000000,32'h12345678} (word3..word0), send 'p' → TX 16 bytes in order: 12 34 56 78 00 00 00 00 DD CC BB AA 44 33 22 11.
  - With DEBUG_CHECKSUM_EN: 17th byte = XOR of those 16 bytes.
- Change dbg_data during the dump → transmitted bytes still match the snapshot taken in DECODE.
- Send 'x' → single TX 0x3F. Second rx_done pulse during that reply → dropped, only one TX byte. rx_done held high 5 cycles → one command only.
- Assert reset in the middle of a 'p' dump → next cycle: tx_start=0, busy=0, enable=0. A following 'c' works normally.
